// File: rtl/cfu_ctx_acc_pkg.sv
// Shared types and parameter checks for the cfu_ctx_acc CFU-LI level-1
// stateful accumulator.
// Contents:
//   cfu_status_t, cfu_cs_e, cfu_csw_t, cfid_t - CFU-LI status and state types
//   cfu_ctx_func_t                            - custom function ids
//   CFU_CTX_ERR_OVF                           - error code for accumulator carry-out
//   check_cfu_l1_params, check_cfu_ctx_params - elaboration-time sanity checks
package cfu_ctx_acc_pkg;

  typedef enum logic [2:0] {
    CFU_OK           = 3'd0,
    CFU_ERROR_CFU    = 3'd1,
    CFU_ERROR_OFF    = 3'd2,
    CFU_ERROR_STATE  = 3'd3,
    CFU_ERROR_FUNC   = 3'd4,
    CFU_ERROR_OP     = 3'd5,
    CFU_ERROR_CUSTOM = 3'd6
  } cfu_status_t;

  typedef enum logic [1:0] {
    CFU_OFF   = 2'd0,
    CFU_INIT  = 2'd1,
    CFU_CLEAN = 2'd2,
    CFU_DIRTY = 2'd3
  } cfu_cs_e;

  // Control/status word as seen by read_status / write_status
  typedef struct packed {
    logic [7:0]  error;
    logic [11:0] rsvd;
    logic [9:0]  state_size;
    cfu_cs_e     cs;
  } cfu_csw_t;

  typedef enum logic [9:0] {
    CFID_WRITE_STATE  = 10'd1020,
    CFID_READ_STATE   = 10'd1021,
    CFID_WRITE_STATUS = 10'd1022,
    CFID_READ_STATUS  = 10'd1023
  } cfid_t;

  typedef enum logic [9:0] {
    CF_ACC   = 10'd0,
    CF_READ  = 10'd1,
    CF_CLEAR = 10'd2
  } cfu_ctx_func_t;

  localparam logic [7:0] CFU_CTX_ERR_OVF = 8'h01;

  function automatic bit check_cfu_l1_params(input int version, input int latency,
                                             input int func_w, input int data_w);
    return (version == 100) && (latency == 1) && (func_w == 10) &&
           ((data_w == 32) || (data_w == 64));
  endfunction

  function automatic bit check_cfu_ctx_params(input int state_id_max, input int state_id_w,
                                              input int state_words);
    bit pow2;
    pow2 = (state_words > 0) && ((state_words & (state_words - 1)) == 0);
    return (state_id_max >= 1) && (state_id_max <= (1 << state_id_w)) &&
           pow2 && (state_words <= 1023);
  endfunction

endpackage

// File: rtl/cfu_ctx_acc_bank.sv
// One state context of cfu_ctx_acc: accumulator words, cs, error field and
// the save/restore word index. All updates are strobes from the top level,
// which has already qualified them with accept and context select.
// Ports:
//   clk, rst_n, clk_en         - clock, async active-low reset, clock enable
//   cs_we/cs_wdata             - write cs
//   err_we/err_wdata           - write error field
//   idx_clr / idx_inc          - reset or advance (wrapping) the save/restore index
//   clear                      - zero all words (wins over word_we)
//   word_we/word_idx/word_wdata- write one word
//   cs, err, idx, words        - current context contents
module cfu_ctx_acc_bank
  import cfu_ctx_acc_pkg::*;
#(
  parameter int CFU_DATA_W      = 32,
  parameter int CFU_STATE_WORDS = 4,
  localparam int IW = (CFU_STATE_WORDS > 1) ? $clog2(CFU_STATE_WORDS) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clk_en,
  input  logic                                      cs_we,
  input  cfu_cs_e                                   cs_wdata,
  input  logic                                      err_we,
  input  logic [7:0]                                err_wdata,
  input  logic                                      idx_clr,
  input  logic                                      idx_inc,
  input  logic                                      clear,
  input  logic                                      word_we,
  input  logic [IW-1:0]                             word_idx,
  input  logic [CFU_DATA_W-1:0]                     word_wdata,
  output cfu_cs_e                                   cs,
  output logic [7:0]                                err,
  output logic [IW-1:0]                             idx,
  output logic [CFU_STATE_WORDS-1:0][CFU_DATA_W-1:0] words
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs    <= CFU_OFF;
      err   <= '0;
      idx   <= '0;
      words <= '0;
    end else if (clk_en) begin
      if (cs_we)  cs  <= cs_wdata;
      if (err_we) err <= err_wdata;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= (idx == IW'(CFU_STATE_WORDS - 1)) ? '0 : idx + 1'b1;
      for (int w = 0; w < CFU_STATE_WORDS; w++) begin
        if (clear)                                words[w] <= '0;
        else if (word_we && (word_idx == IW'(w))) words[w] <= word_wdata;
      end
    end
  end

endmodule

// File: rtl/cfu_ctx_acc.sv
// cfu_ctx_acc: CFU-LI level-1 stateful accumulator with CFU_STATE_ID_MAX
// independent contexts. Decodes requests, applies the error priority,
// drives the per-context banks and registers the single-cycle response.
// Optional build macro: CFU_CTX_OVF_ERR_EN - a CF_ACC carry-out latches
// error=CFU_CTX_ERR_OVF and returns CFU_ERROR_CUSTOM; the context then
// rejects non-status functions until write_status clears the error.
// Ports:
//   clk, rst_n, clk_en                     - clock, async active-low reset, clock enable
//   req_valid/req_ready                    - request handshake
//   req_cfu, req_state, req_func           - CFU id, context id, function id
//   req_data0, req_data1                   - operands
//   resp_valid/resp_ready                  - response handshake
//   resp_status, resp_data                 - registered response
module cfu_ctx_acc
  import cfu_ctx_acc_pkg::*;
#(
  parameter int CFU_VERSION       = 100,
  parameter int CFU_LATENCY       = 1,
  parameter int CFU_RESET_LATENCY = 0,
  parameter int CFU_CFU_ID_W      = 1,
  parameter int CFU_STATE_ID_MAX  = 4,
  parameter int CFU_STATE_ID_W    = 2,
  parameter int CFU_FUNC_ID_W     = 10,
  parameter int CFU_DATA_W        = 32,
  parameter int CFU_STATE_WORDS   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CFU_CFU_ID_W-1:0]   req_cfu,
  input  logic [CFU_STATE_ID_W-1:0] req_state,
  input  logic [CFU_FUNC_ID_W-1:0]  req_func,
  input  logic [CFU_DATA_W-1:0]     req_data0,
  input  logic [CFU_DATA_W-1:0]     req_data1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output cfu_status_t               resp_status,
  output logic [CFU_DATA_W-1:0]     resp_data
);

  localparam int IW  = (CFU_STATE_WORDS > 1) ? $clog2(CFU_STATE_WORDS) : 1;
  localparam int RLW = (CFU_RESET_LATENCY > 0) ? $clog2(CFU_RESET_LATENCY + 1) : 1;

  if (!check_cfu_l1_params(CFU_VERSION, CFU_LATENCY, CFU_FUNC_ID_W, CFU_DATA_W)) begin : g_bad_l1
    $error("cfu_ctx_acc: unsupported CFU-LI level-1 parameters");
  end
  if (!check_cfu_ctx_params(CFU_STATE_ID_MAX, CFU_STATE_ID_W, CFU_STATE_WORDS)) begin : g_bad_ctx
    $error("cfu_ctx_acc: unsupported context parameters");
  end

  // Wrapping add; the extra MSB is the unsigned carry-out.
  function automatic logic [CFU_DATA_W:0] acc_add(input logic [CFU_DATA_W-1:0] a,
                                                  input logic [CFU_DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Holds req_ready low for CFU_RESET_LATENCY enabled cycles after reset.
  logic [RLW-1:0] rst_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       rst_cnt <= RLW'(CFU_RESET_LATENCY);
    else if (clk_en && rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
  end

  logic accept;
  assign req_ready = (rst_cnt == '0) && (!resp_valid || resp_ready);
  assign accept    = clk_en && req_valid && req_ready;

  cfu_cs_e                                   bank_cs    [CFU_STATE_ID_MAX];
  logic [7:0]                                bank_err   [CFU_STATE_ID_MAX];
  logic [IW-1:0]                             bank_idx   [CFU_STATE_ID_MAX];
  logic [CFU_STATE_WORDS-1:0][CFU_DATA_W-1:0] bank_words [CFU_STATE_ID_MAX];

  cfu_cs_e                                   cur_cs;
  logic [7:0]                                cur_err;
  logic [IW-1:0]                             cur_idx;
  logic [CFU_STATE_WORDS-1:0][CFU_DATA_W-1:0] cur_words;

  always_comb begin
    cur_cs    = CFU_OFF;
    cur_err   = '0;
    cur_idx   = '0;
    cur_words = '0;
    for (int i = 0; i < CFU_STATE_ID_MAX; i++) begin
      if (req_state == CFU_STATE_ID_W'(i)) begin
        cur_cs    = bank_cs[i];
        cur_err   = bank_err[i];
        cur_idx   = bank_idx[i];
        cur_words = bank_words[i];
      end
    end
  end

  // Stage p0: decode, error priority and bank strobes
  logic                  is_status_p0, func_known_p0;
  logic [IW-1:0]         acc_k_p0;
  logic [CFU_DATA_W:0]   acc_sum_p0;
  cfu_csw_t              csw_p0;
  cfu_status_t           status_p0;
  logic [CFU_DATA_W-1:0] rdata_p0;
  logic                  cs_we_p0, err_we_p0, idx_clr_p0, idx_inc_p0, clear_p0, word_we_p0;
  cfu_cs_e               cs_wdata_p0;
  logic [7:0]            err_wdata_p0;
  logic [IW-1:0]         word_idx_p0;

  assign is_status_p0  = (req_func == CFID_WRITE_STATUS) || (req_func == CFID_READ_STATUS);
  assign func_known_p0 = (req_func == CF_ACC) || (req_func == CF_READ) || (req_func == CF_CLEAR) ||
                         (req_func >= CFID_WRITE_STATE);
  assign acc_k_p0      = req_data1[IW-1:0] & IW'(CFU_STATE_WORDS - 1);
  assign acc_sum_p0    = acc_add(cur_words[acc_k_p0], req_data0);

  always_comb begin
    csw_p0            = '0;
    csw_p0.error      = cur_err;
    csw_p0.state_size = 10'(CFU_STATE_WORDS);
    csw_p0.cs         = cur_cs;
  end

  always_comb begin
    status_p0    = CFU_OK;
    rdata_p0     = '0;
    cs_we_p0     = 1'b0;
    cs_wdata_p0  = CFU_DIRTY;
    err_we_p0    = 1'b0;
    err_wdata_p0 = '0;
    idx_clr_p0   = 1'b0;
    idx_inc_p0   = 1'b0;
    clear_p0     = 1'b0;
    word_we_p0   = 1'b0;
    word_idx_p0  = cur_idx;
    if (req_cfu != '0) begin
      status_p0 = CFU_ERROR_CFU;
    end else if (32'(req_state) >= CFU_STATE_ID_MAX) begin
      status_p0 = CFU_ERROR_STATE;
    end else if (!func_known_p0) begin
      status_p0 = CFU_ERROR_FUNC;
    end else if (cur_cs == CFU_OFF && !is_status_p0) begin
      status_p0 = CFU_ERROR_OFF;
`ifdef CFU_CTX_OVF_ERR_EN
    end else if (cur_err != '0 && !is_status_p0) begin
      status_p0 = CFU_ERROR_CUSTOM;
`endif
    end else begin
      case (req_func)
        CFID_READ_STATUS: rdata_p0 = CFU_DATA_W'(csw_p0);
        CFID_WRITE_STATUS: begin
          cs_we_p0     = 1'b1;
          cs_wdata_p0  = cfu_cs_e'(req_data0[1:0]);
          err_we_p0    = 1'b1;
          err_wdata_p0 = req_data0[31:24];
          idx_clr_p0   = 1'b1;
          clear_p0     = (cfu_cs_e'(req_data0[1:0]) == CFU_INIT);
        end
        CFID_READ_STATE: begin
          rdata_p0   = cur_words[cur_idx];
          idx_inc_p0 = 1'b1;
        end
        CFID_WRITE_STATE: begin
          word_we_p0 = 1'b1;
          idx_inc_p0 = 1'b1;
          cs_we_p0   = 1'b1;
        end
        CF_ACC: begin
          word_we_p0  = 1'b1;
          word_idx_p0 = acc_k_p0;
          rdata_p0    = acc_sum_p0[CFU_DATA_W-1:0];
          cs_we_p0    = 1'b1;
`ifdef CFU_CTX_OVF_ERR_EN
          if (acc_sum_p0[CFU_DATA_W]) begin
            err_we_p0    = 1'b1;
            err_wdata_p0 = CFU_CTX_ERR_OVF;
            status_p0    = CFU_ERROR_CUSTOM;
          end
`endif
        end
        CF_READ: rdata_p0 = cur_words[acc_k_p0];
        CF_CLEAR: begin
          clear_p0    = 1'b1;
          cs_we_p0    = 1'b1;
          cs_wdata_p0 = CFU_INIT;
        end
        default: status_p0 = CFU_ERROR_FUNC;
      endcase
    end
  end

  // write_state stores operand 0; CF_ACC stores the wrapped sum
  logic [CFU_DATA_W-1:0] word_wdata_p0;
  assign word_wdata_p0 = (req_func == CF_ACC) ? acc_sum_p0[CFU_DATA_W-1:0] : req_data0;

  for (genvar i = 0; i < CFU_STATE_ID_MAX; i++) begin : g_ctx
    logic sel;
    assign sel = accept && (req_state == CFU_STATE_ID_W'(i));
    cfu_ctx_acc_bank #(
      .CFU_DATA_W     (CFU_DATA_W),
      .CFU_STATE_WORDS(CFU_STATE_WORDS)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .clk_en    (clk_en),
      .cs_we     (sel && cs_we_p0),
      .cs_wdata  (cs_wdata_p0),
      .err_we    (sel && err_we_p0),
      .err_wdata (err_wdata_p0),
      .idx_clr   (sel && idx_clr_p0),
      .idx_inc   (sel && idx_inc_p0),
      .clear     (sel && clear_p0),
      .word_we   (sel && word_we_p0),
      .word_idx  (word_idx_p0),
      .word_wdata(word_wdata_p0),
      .cs        (bank_cs[i]),
      .err       (bank_err[i]),
      .idx       (bank_idx[i]),
      .words     (bank_words[i])
    );
  end

  // Stage p1: response register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_status <= CFU_OK;
      resp_data   <= '0;
    end else if (clk_en) begin
      if (accept) begin
        resp_valid  <= 1'b1;
        resp_status <= status_p0;
        resp_data   <= rdata_p0;
      end else if (resp_ready) begin
        resp_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cfu_ctx_acc.md
Name: cfu_ctx_acc

Overview:
Stateful CFU-LI level-1 accumulator CFU with CFU_STATE_ID_MAX independent state contexts. Each context holds CFU_STATE_WORDS accumulator words, a CS status, a custom error field and a save/restore word index. The block implements the standard status/state CFIDs (1020-1023) plus custom accumulate/read functions. It sits behind the CPU's CFU-LI request/response channel, and the OS uses it for context save/restore.

Parameters:
CFU_VERSION, 100, CFU-LI version; checked with check_cfu_l1_params.
CFU_LATENCY, 1, fixed response latency (only 1 supported).
CFU_RESET_LATENCY, 0, cycles after reset deassert before req_ready may rise.
CFU_CFU_ID_W, 1, width of req_cfu.
CFU_STATE_ID_MAX, 4, number of state contexts; must be ≤ 2^CFU_STATE_ID_W.
CFU_STATE_ID_W, 2, width of req_state.
CFU_FUNC_ID_W, 10, width of req_func; must be 10.
CFU_DATA_W, 32, data width; must be 32 or 64.
CFU_STATE_WORDS, 4, accumulator words per context; must be a power of 2 and ≤ 1023.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  clock enable; when low, no state or output changes
req_valid  in  1  request valid
req_ready  out  1  request ready
req_cfu  in  CFU_CFU_ID_W  CFU id
req_state  in  CFU_STATE_ID_W  state context id
req_func  in  CFU_FUNC_ID_W  custom function id
req_data0  in  CFU_DATA_W  operand 0
req_data1  in  CFU_DATA_W  operand 1
resp_valid  out  1  response valid
resp_ready  in  1  response ready
resp_status  out  3  cfu_status_t
resp_data  out  CFU_DATA_W  response data

Behaviour:
- Reset (async, rst_n=0):
  - resp_valid=0, resp_status=CFU_OK, resp_data=0.
  - All contexts: cs=CFU_OFF, error=0, index=0, words=0.
  - req_ready=0 for the CFU_RESET_LATENCY cycles after deassert.
- Handshake:
  - req_ready = !resp_valid || resp_ready.
  - Request is accepted on a clk_en edge with req_valid && req_ready.
  - The response is registered: resp_valid rises on the next edge, so latency = 1.
  - Back-to-back accepts are allowed when resp_ready=1.
  - resp_* are held stable while resp_valid && !resp_ready.
- Error priority (first match wins; on error resp_data=0 and no state change):
  1. req_cfu≠0 → CFU_ERROR_CFU.
  2. req_state ≥ CFU_STATE_ID_MAX → CFU_ERROR_STATE.
  3. Unknown func → CFU_ERROR_FUNC.
  4. Context cs=OFF and func is not 1022/1023 → CFU_ERROR_OFF.
- cfid_read_status (1023):
  - Returns cfu_csw_t: {error, 12'b0, state_size=CFU_STATE_WORDS, cs}, zero-extended to CFU_DATA_W.
  - Allowed when OFF.
- cfid_write_status (1022):
  - cs←data0.cs and error←data0.error; reserved and state_size are ignored.
  - index←0.
  - If the new cs=INIT, all words of that context are cleared in the same edge.
  - Returns 0.
- cfid_read_state (1021):
  - Returns words[index]; index←(index+1) mod CFU_STATE_WORDS.
  - cs unchanged.
- cfid_write_state (1020):
  - words[index]←data0; index wraps as for read_state.
  - cs←DIRTY; returns 0.
- CF_ACC (0):
  - k = data1[log2(CFU_STATE_WORDS)-1:0]; words[k]←words[k]+data0 mod 2^CFU_DATA_W.
  - Returns the new value; cs←DIRTY.
- CF_READ (1): returns words[data1 index]; cs unchanged.
- CF_CLEAR (2): zeroes all words; cs←INIT; index unchanged; returns 0.
- Other contexts are never disturbed.
- clk_en=0 mid-transaction: everything freezes, including a pending response.

Optional Feature:
Macro CFU_CTX_OVF_ERR_EN.
- Defined:
  - A CF_ACC whose unsigned sum carries out still writes the wrapped sum and sets cs←DIRTY.
  - It also sets error←8'h01 and returns the wrapped sum with status CFU_ERROR_CUSTOM.
  - Any subsequent non-status request to that context while error≠0 returns CFU_ERROR_CUSTOM with no effect, until write_status clears the error.
- Undefined: overflow wraps silently, status is CFU_OK, and the error field changes only via write_status.

Decomposition:
- Add to cfu_pkg:
  - enum cfu_ctx_func_t {CF_ACC=0, CF_READ=1, CF_CLEAR=2}.
  - localparam CFU_CTX_ERR_OVF=8'h01.
  - check_cfu_ctx_params (state_id_max vs state_id_w, state_words power of 2).
- Reuse cfu_csw_t, cfu_cs_e, cfu_status_t and cfid_t.
- Sub-module cfu_ctx_bank: one context's words/cs/error/index, with write/clear/inc strobes; generated CFU_STATE_ID_MAX times.
- Top level owns decode, error priority and the response register.

Test Plan:
1. After reset: read_status ctx0 → CFU_OK, data=0x00000010 (state_size=4, cs=OFF). CF_ACC ctx0 → CFU_ERROR_OFF, data 0.
2. write_status ctx1 cs=INIT; CF_ACC data0=5, data1=2 twice → resp 5 then 10, both OK. read_status → cs=DIRTY(3); ctx0 remains OFF.
3. Save/restore: read_state ×5 on ctx1 → 0, 0, 10, 0, 0 (index wraps). Then write_status INIT, write_state 1,2,3,4, CF_READ idx3 → 4.
4. Errors: req_cfu=1 → ERROR_CFU; req_state=3 with req_func=7 → ERROR_FUNC; req_state=4 with CFU_STATE_ID_W=3 → ERROR_STATE; cfu=1 with state=4 → ERROR_CFU (priority).
5. Backpressure: hold resp_ready=0 for 3 cycles with req_valid=1 → req_ready=0 and resp stable. Release → next request accepted the same cycle and its response follows one cycle later. Assert rst_n=0 mid-stall → resp_valid=0 immediately.
6. With CFU_CTX_OVF_ERR_EN: word=0xFFFFFFFF, CF_ACC data0=2 → data 1, CFU_ERROR_CUSTOM, csw.error=1. Next CF_READ → CUSTOM. Without the macro: data 1, CFU_OK.
